// File: rtl/aoc_decimal_feeder.sv
// ASCII decimal stream parser: turns whitespace/comma separated unsigned numbers
// into a registered value/enable strobe stream for a solver block.
module aoc_decimal_feeder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] value,
    output logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             overflow,
    output logic             format_error
);

    localparam int unsigned XW = WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NUMBER = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;

    logic             is_digit_c;
    logic             is_sep_c;
    logic [XW-1:0]    prod_c;
    logic             prod_ovf_c;

    // Byte classification and the widened acc*10 + d step.
    always_comb begin
        is_digit_c = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_sep_c   = (in_data == 8'h0A) || (in_data == 8'h0D) || (in_data == 8'h20) ||
                     (in_data == 8'h09) || (in_data == 8'h2C);
        prod_c     = XW'(acc) * XW'(10) + XW'(in_data - 8'h30);
        prod_ovf_c = (prod_c[XW-1:WIDTH] != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            in_ready     <= 1'b1;
            value        <= '0;
            enable       <= 1'b0;
            count        <= '0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            format_error <= 1'b0;
        end else begin
            enable <= 1'b0;
            if (in_valid && in_ready) begin
                if (is_digit_c) begin
                    acc   <= prod_c[WIDTH-1:0];
                    state <= NUMBER;
                    if (prod_ovf_c) begin
                        overflow <= 1'b1;
                    end
                    // Final digit with no trailing separator still closes the number.
                    if (in_last) begin
                        value  <= prod_c[WIDTH-1:0];
                        enable <= 1'b1;
                        count  <= count + WIDTH'(1);
                    end
                end else begin
                    if (!is_sep_c) begin
                        format_error <= 1'b1;
                    end
                    if (state == NUMBER) begin
                        value  <= acc;
                        enable <= 1'b1;
                        count  <= count + WIDTH'(1);
                    end
                    acc   <= '0;
                    state <= IDLE;
                end
                if (in_last) begin
                    state    <= DONE;
                    done     <= 1'b1;
                    in_ready <= 1'b0;
                end
            end
        end
    end

endmodule
